board_draw_ctl: RTL and testbench

- Renders one 10x10 battleship board into the VGA pixel stream by sequencing the shared sprite ROM (7-bit address, 32-bit line, 1-cycle registered read).
- For each incoming pixel it computes the board cell, fetches that cell's state from board memory (1-cycle synchronous read), forms the ROM address and selects the pixel bit. It then colours the pixel and delays all timing signals to match.
- Sits between the background/grid drawer and the mouse/cursor overlay in the VGA chain.

---
 rtl/board_pkg.sv | 52 +++++
 rtl/delay.sv | 25 ++
 rtl/board_draw_ctl.sv | 159 +++++++++++++++
 tb/tb_board_draw_ctl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared types, sprite codes and colours for the battleship board renderer
package board_pkg;

    localparam int BOARD_CELLS = 10;

    typedef enum logic [1:0] {
        CS_EMPTY = 2'd0,
        CS_SHIP  = 2'd1,
        CS_HIT   = 2'd2,
        CS_MISS  = 2'd3
    } cell_state_t;

    // Sprite code is the top two bits of the ROM address; each sprite owns 32 lines.
    typedef enum logic [1:0] {
        SPR_SHIP  = 2'b00,
        SPR_EMPTY = 2'b01,
        SPR_HIT   = 2'b10,
        SPR_MISS  = 2'b11
    } sprite_code_t;

    localparam logic [6:0]  SPRITE_EMPTY_ADDR = 7'h20;

    localparam logic [11:0] RGB_SHIP  = 12'h888;
    localparam logic [11:0] RGB_EMPTY = 12'hFFF;
    localparam logic [11:0] RGB_HIT   = 12'hF00;
    localparam logic [11:0] RGB_MISS  = 12'hFFF;

    function automatic sprite_code_t sprite_code(input cell_state_t s);
        sprite_code_t c;
        c = SPR_EMPTY;
        case (s)
            CS_SHIP: c = SPR_SHIP;
            CS_HIT:  c = SPR_HIT;
            CS_MISS: c = SPR_MISS;
            default: c = SPR_EMPTY;
        endcase
        return c;
    endfunction

    function automatic logic [11:0] state_rgb(input cell_state_t s);
        logic [11:0] c;
        c = RGB_EMPTY;
        case (s)
            CS_SHIP: c = RGB_SHIP;
            CS_HIT:  c = RGB_HIT;
            CS_MISS: c = RGB_MISS;
            default: c = RGB_EMPTY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/delay.sv
// rtl/delay.sv - resettable CLK_DEL-stage shift register for timing and colour pass-through
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [CLK_DEL];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLK_DEL; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < CLK_DEL; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_data = r_pipe[CLK_DEL-1];

endmodule

// File: rtl/board_draw_ctl.sv
// rtl/board_draw_ctl.sv - 3-stage pipeline drawing a 10x10 board from cell memory and the sprite ROM
module board_draw_ctl
    import board_pkg::*;
#(
    parameter int          X0         = 64,
    parameter int          Y0         = 64,
    parameter int          CELLS      = BOARD_CELLS,
    parameter int          CELL_W     = 32,
    parameter int          CELL_H     = 16,
    parameter logic [11:0] WATER_RGB  = 12'h03A,
    parameter logic [11:0] CURSOR_RGB = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        vblnk_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        cursor_en,
    input  logic [3:0]  cursor_x,
    input  logic [3:0]  cursor_y,
    output logic [3:0]  cell_x,
    output logic [3:0]  cell_y,
    input  logic [1:0]  cell_state,
    output logic [6:0]  rom_addr,
    input  logic [31:0] rom_line,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        vblnk_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out
);

    // Range check uses the raw counts so pixels left of/above the board never wrap in.
    logic [8:0] w_dx;
    logic [7:0] w_dy;
    logic       w_in_board;

    assign w_dx = 9'(hcount_in - 11'(X0));
    assign w_dy = 8'(vcount_in - 11'(Y0));
    assign w_in_board = (hcount_in >= 11'(X0)) && (hcount_in < 11'(X0 + CELLS*CELL_W)) &&
                        (vcount_in >= 11'(Y0)) && (vcount_in < 11'(Y0 + CELLS*CELL_H));

    logic [3:0] r_cell_x, r_cell_y;
    logic [4:0] r_col0;
    logic [3:0] r_row0;
    logic       r_in0, r_edge0, r_cur_en0;
    logic [3:0] r_cur_x0, r_cur_y0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cell_x  <= '0;
            r_cell_y  <= '0;
            r_col0    <= '0;
            r_row0    <= '0;
            r_in0     <= 1'b0;
            r_edge0   <= 1'b0;
            r_cur_en0 <= 1'b0;
            r_cur_x0  <= '0;
            r_cur_y0  <= '0;
        end else begin
            if (w_in_board) begin
                r_cell_x <= w_dx[8:5];
                r_cell_y <= w_dy[7:4];
            end
            r_col0    <= w_dx[4:0];
            r_row0    <= w_dy[3:0];
            r_in0     <= w_in_board;
            r_edge0   <= (w_dx[4:0] == 5'd0) || (w_dx[4:0] == 5'd31) ||
                         (w_dy[3:0] == 4'd0) || (w_dy[3:0] == 4'd15);
            r_cur_en0 <= cursor_en;
            r_cur_x0  <= cursor_x;
            r_cur_y0  <= cursor_y;
        end
    end

    assign cell_x = r_cell_x;
    assign cell_y = r_cell_y;

    logic [6:0]  w_rom_addr;
    logic [6:0]  r_rom_addr;
    logic        r_in1, r_edge1, r_cur1;
    logic [4:0]  r_col1;
    cell_state_t r_state1;

    assign w_rom_addr = r_in0 ? {sprite_code(cell_state_t'(cell_state)), 1'b0, r_row0}
                              : SPRITE_EMPTY_ADDR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr <= SPRITE_EMPTY_ADDR;
            r_in1      <= 1'b0;
            r_edge1    <= 1'b0;
            r_cur1     <= 1'b0;
            r_col1     <= '0;
            r_state1   <= CS_EMPTY;
        end else begin
            r_rom_addr <= w_rom_addr;
            r_in1      <= r_in0;
            r_edge1    <= r_edge0;
            r_cur1     <= r_cur_en0 && (r_cell_x == r_cur_x0) && (r_cell_y == r_cur_y0);
            r_col1     <= r_col0;
            r_state1   <= cell_state_t'(cell_state);
        end
    end

    assign rom_addr = r_rom_addr;

    // Blanks and upstream colour are tapped after two stages to line up with rom_line.
    logic        w_vb2, w_hb2;
    logic [11:0] w_rgb2;

    delay #(.WIDTH(14), .CLK_DEL(2)) u_colour_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data ({vblnk_in, hblnk_in, rgb_in}),
        .o_data ({w_vb2, w_hb2, w_rgb2})
    );

    delay #(.WIDTH(26), .CLK_DEL(3)) u_timing_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data ({vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in}),
        .o_data ({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out})
    );

    logic [4:0]  w_bit_idx;
    logic        w_bit;
    logic [11:0] w_rgb;
    logic [11:0] r_rgb;

    assign w_bit_idx = 5'd31 - r_col1;
    assign w_bit     = rom_line[w_bit_idx];

    always_comb begin
        w_rgb = WATER_RGB;
        if (w_vb2 || w_hb2)
            w_rgb = 12'h000;
        else if (!r_in1)
            w_rgb = w_rgb2;
        else if (r_cur1 && r_edge1)
            w_rgb = CURSOR_RGB;
        else if (w_bit)
            w_rgb = state_rgb(r_state1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rgb <= '0;
        else        r_rgb <= w_rgb;
    end

    assign rgb_out = r_rgb;

endmodule

// File: tb/tb_board_draw_ctl.sv
// tb/tb_board_draw_ctl.sv - randomized and directed self-checking bench for board_draw_ctl
module tb_board_draw_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] vcount_in = '0, hcount_in = '0;
    logic        vsync_in = 1'b0, hsync_in = 1'b0, vblnk_in = 1'b0, hblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic        cursor_en = 1'b0;
    logic [3:0]  cursor_x = '0, cursor_y = '0;
    logic [3:0]  cell_x, cell_y;
    logic [1:0]  cell_state;
    logic [6:0]  rom_addr;
    logic [31:0] rom_line;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
    logic [11:0] rgb_out;

    logic [1:0]  board   [16][16];
    logic [31:0] rom_mem [128];

    assign cell_state = board[cell_y][cell_x];
    assign rom_line   = rom_mem[rom_addr];

    always #5 clk = ~clk;

    board_draw_ctl dut (
        .clk(clk), .rst_n(rst_n),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in),
        .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cell_x(cell_x), .cell_y(cell_y), .cell_state(cell_state),
        .rom_addr(rom_addr), .rom_line(rom_line),
        .vcount_out(vcount_out), .hcount_out(hcount_out),
        .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic [25:0] tim;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [25:0] tim_out;
    assign tim_out = {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference: colour of one pixel from the board/sprite rules, using the current memories and cursor.
    function automatic logic [11:0] model_rgb(input int h, input int v, input logic [11:0] rgb,
                                              input logic vb, input logic hb);
        int          col, row, cx, cy;
        logic [1:0]  st;
        logic [6:0]  base;
        logic [31:0] line;
        if (vb || hb) return 12'h000;
        if (h < 64 || h >= 64 + 320 || v < 64 || v >= 64 + 160) return rgb;
        cx  = (h - 64) / 32;
        cy  = (v - 64) / 16;
        col = (h - 64) % 32;
        row = (v - 64) % 16;
        if (cursor_en && cursor_x == 4'(cx) && cursor_y == 4'(cy) &&
            (col == 0 || col == 31 || row == 0 || row == 15))
            return 12'hFF0;
        st = board[4'(cy)][4'(cx)];
        case (st)
            2'd0:    base = 7'h20;
            2'd1:    base = 7'h00;
            2'd2:    base = 7'h40;
            default: base = 7'h60;
        endcase
        line = rom_mem[base + 7'(row)];
        if (!line[5'(31 - col)]) return 12'h03A;
        case (st)
            2'd1:    return 12'h888;
            2'd2:    return 12'hF00;
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic cycle(input logic [11:0] rgb_exp);
        exp_t e;
        e.rgb = rgb_exp;
        e.tim = {vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in};
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (q.size() >= 3) begin
            e = q.pop_front();
            check("rgb_out", 32'(rgb_out), 32'(e.rgb));
            check("timing", 32'(tim_out), 32'(e.tim));
        end
    endtask

    task automatic set_px(input int h, input int v, input logic [11:0] rgb,
                          input logic vb, input logic hb);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        rgb_in    = rgb;
        vblnk_in  = vb;
        hblnk_in  = hb;
        vsync_in  = 1'($urandom);
        hsync_in  = 1'($urandom);
    endtask

    task automatic px_exp(input int h, input int v, input logic [11:0] rgb,
                          input logic vb, input logic hb, input logic [11:0] ex);
        set_px(h, v, rgb, vb, hb);
        cycle(ex);
    endtask

    task automatic px_model(input int h, input int v, input logic [11:0] rgb,
                            input logic vb, input logic hb);
        set_px(h, v, rgb, vb, hb);
        cycle(model_rgb(h, v, rgb, vb, hb));
    endtask

    task automatic idle();
        logic [11:0] c;
        c = 12'($urandom);
        px_exp(0, 0, c, 1'b0, 1'b0, c);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            set_px(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 12'($urandom),
                   1'($urandom), 1'($urandom));
            @(posedge clk);
            @(negedge clk);
            check("rst_rgb", 32'(rgb_out), 32'h0);
            check("rst_rom", 32'(rom_addr), 32'h20);
            check("rst_tim", 32'(tim_out), 32'h0);
            check("rst_cell", 32'({cell_y, cell_x}), 32'h0);
        end
        q.delete();
        q.push_back('0);
        q.push_back('0);
        rst_n = 1'b1;
    endtask

    logic [11:0] c;

    initial begin
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) board[y][x] = 2'($urandom);
        for (int a = 0; a < 128; a++) rom_mem[a] = $urandom;

        @(negedge clk);
        do_reset(3);

        // Directed cases
        board[0][0] = 2'd1;  rom_mem[7'h00] = 32'hFFFFFFFF;
        board[2][3] = 2'd3;  rom_mem[7'h6E] = 32'hF8110000;
        px_exp(64, 64, 12'h123, 1'b0, 1'b0, 12'h888);
        check("org_cell", 32'({cell_y, cell_x}), 32'h00);
        px_exp(64 + 3*32 + 4, 64 + 2*16 + 14, 12'h456, 1'b0, 1'b0, 12'hFFF);
        check("org_rom", 32'(rom_addr), 32'h00);
        check("miss_cell", 32'({cell_y, cell_x}), 32'h23);
        px_exp(64 + 3*32 + 5, 64 + 2*16 + 14, 12'h456, 1'b0, 1'b0, 12'h03A);
        check("miss_rom", 32'(rom_addr), 32'h6E);
        px_exp(384, 100, 12'hABC, 1'b0, 1'b0, 12'hABC);
        check("hold_cell", 32'({cell_y, cell_x}), 32'h23);
        px_exp(384, 100, 12'hABC, 1'b0, 1'b1, 12'h000);
        check("out_rom", 32'(rom_addr), 32'h20);

        board[5][2] = 2'd0;  rom_mem[7'h20] = 32'h80000000;
        cursor_x = 4'd2; cursor_y = 4'd5; cursor_en = 1'b1;
        px_exp(128, 144, 12'h111, 1'b0, 1'b0, 12'hFF0);
        px_model(129, 145, 12'h111, 1'b0, 1'b0);
        cursor_en = 1'b0;
        px_exp(128, 144, 12'h111, 1'b0, 1'b0, 12'hFFF);
        cursor_en = 1'b1; cursor_x = 4'd12;
        px_exp(128, 144, 12'h111, 1'b0, 1'b0, 12'hFFF);
        cursor_en = 1'b0;

        board[0][9] = 2'd2;  rom_mem[7'h40] = 32'h00000001;
        px_exp(383, 64, 12'h222, 1'b0, 1'b0, 12'hF00);
        px_exp(384, 64, 12'h333, 1'b0, 1'b0, 12'h333);
        px_exp(63, 100, 12'h444, 1'b0, 1'b0, 12'h444);
        px_model(64, 223, 12'h555, 1'b0, 1'b0);
        px_exp(64, 224, 12'h666, 1'b0, 1'b0, 12'h666);
        px_exp(200, 100, 12'h777, 1'b1, 1'b0, 12'h000);
        for (int i = 0; i < 3; i++) idle();

        // Random scan lines over a random board, cursor wandering, with a mid-line reset
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++) board[y][x] = 2'($urandom);
        for (int line = 0; line < 28; line++) begin
            int v;
            v = int'($urandom_range(56, 232));
            for (int h = 56; h <= 392; h++) begin
                if ($urandom_range(0, 49) == 0) begin
                    cursor_en = 1'($urandom);
                    cursor_x  = 4'($urandom_range(0, 11));
                    cursor_y  = 4'($urandom_range(0, 11));
                end
                if (line == 10 && h == 150) do_reset(2);
                c = 12'($urandom);
                px_model(h, v, c, 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 31) == 0));
            end
        end
        for (int i = 0; i < 3; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
